// File: rtl/apb_pkg.sv
// APB requester shared definitions.
// State encoding, default sizing, response flag layout.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int APB_ADDR_WIDTH_DEF = 32;
  localparam int APB_DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam int WAIT_CNT_W = 5;

  localparam int RSP_ERR_BIT     = 0;
  localparam int RSP_TIMEOUT_BIT = 1;
  localparam int RSP_FLAGS_W     = 2;

endpackage

// File: rtl/apb_master.sv
// APB requester: one command in, one APB transfer, one response out.
// Every APB and response output comes straight from a flop.
module apb_master
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
  parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic                        cmd_write_in,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
  output logic                        rsp_valid_out,
  input  logic                        rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                        rsp_err_out,
  output logic                        rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
  output logic                        apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
  output logic                        apb_psel_out,
  output logic                        apb_penable_out,
  input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
  input  logic                        apb_ready_in,
  input  logic                        apb_slverr_in
);

  localparam int STRB_W = APB_DATA_WIDTH / 8;
  // Counter widens only if a timeout beyond 32 cycles is configured.
  localparam int WAIT_W =
    (TIMEOUT_CYCLES > (1 << WAIT_CNT_W)) ? 8 : WAIT_CNT_W;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT_CYCLES - 1);

  apb_state_t                state, state_nx;
  logic [WAIT_W-1:0]         wait_cnt, wait_nx;
  logic [RSP_FLAGS_W-1:0]    flags, flags_nx;
  logic                      cmd_ready_nx;
  logic                      rsp_valid_nx;
  logic [APB_DATA_WIDTH-1:0] rdata_nx;
  logic [APB_ADDR_WIDTH-1:0] addr_nx;
  logic                      write_nx;
  logic [APB_DATA_WIDTH-1:0] wdata_nx;
  logic [STRB_W-1:0]         strb_nx;
  logic                      psel_nx;
  logic                      penable_nx;

  assign rsp_err_out     = flags[RSP_ERR_BIT];
  assign rsp_timeout_out = flags[RSP_TIMEOUT_BIT];

  // Next state and next value of every registered output.
  always_comb begin
    state_nx     = state;
    wait_nx      = wait_cnt;
    flags_nx     = flags;
    cmd_ready_nx = 1'b0;
    rsp_valid_nx = rsp_valid_out;
    rdata_nx     = rsp_rdata_out;
    addr_nx      = apb_addr_out;
    write_nx     = apb_write_out;
    wdata_nx     = apb_wdata_out;
    strb_nx      = apb_strb_out;
    psel_nx      = 1'b0;
    penable_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid_in && cmd_ready_out) begin
          state_nx = SETUP;
          psel_nx  = 1'b1;
          wait_nx  = '0;
          addr_nx  = cmd_addr_in;
          write_nx = cmd_write_in;
          wdata_nx = cmd_write_in ? cmd_wdata_in : '0;
          strb_nx  = cmd_write_in ? cmd_strb_in : '0;
        end else begin
          cmd_ready_nx = 1'b1;
        end
      end
      SETUP: begin
        state_nx   = ACCESS;
        psel_nx    = 1'b1;
        penable_nx = 1'b1;
      end
      ACCESS: begin
        if (apb_ready_in) begin
          state_nx = RESP;
          rsp_valid_nx = 1'b1;
          rdata_nx = apb_write_out ? '0 : apb_rdata_in;
          flags_nx = '0;
          flags_nx[RSP_ERR_BIT] = apb_slverr_in;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = RESP;
          rsp_valid_nx = 1'b1;
          rdata_nx = '0;
          flags_nx = '0;
          flags_nx[RSP_ERR_BIT] = 1'b1;
          flags_nx[RSP_TIMEOUT_BIT] = 1'b1;
        end else begin
          wait_nx    = wait_cnt + 1'b1;
          psel_nx    = 1'b1;
          penable_nx = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_in) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          cmd_ready_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer.
  always_ff @(posedge apb_clk_in) begin
    if (!apb_rstn_in) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      flags           <= '0;
      cmd_ready_out   <= 1'b0;
      rsp_valid_out   <= 1'b0;
      rsp_rdata_out   <= '0;
      apb_addr_out    <= '0;
      apb_write_out   <= 1'b0;
      apb_wdata_out   <= '0;
      apb_strb_out    <= '0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
    end else begin
      state           <= state_nx;
      wait_cnt        <= wait_nx;
      flags           <= flags_nx;
      cmd_ready_out   <= cmd_ready_nx;
      rsp_valid_out   <= rsp_valid_nx;
      rsp_rdata_out   <= rdata_nx;
      apb_addr_out    <= addr_nx;
      apb_write_out   <= write_nx;
      apb_wdata_out   <= wdata_nx;
      apb_strb_out    <= strb_nx;
      apb_psel_out    <= psel_nx;
      apb_penable_out <= penable_nx;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master.
// Inputs driven and outputs sampled on the falling edge.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_master dut (
    .apb_clk_in      (clk),
    .apb_rstn_in     (rstn),
    .cmd_valid_in    (cmd_valid),
    .cmd_ready_out   (cmd_ready),
    .cmd_addr_in     (cmd_addr),
    .cmd_write_in    (cmd_write),
    .cmd_wdata_in    (cmd_wdata),
    .cmd_strb_in     (cmd_strb),
    .rsp_valid_out   (rsp_valid),
    .rsp_ready_in    (rsp_ready),
    .rsp_rdata_out   (rsp_rdata),
    .rsp_err_out     (rsp_err),
    .rsp_timeout_out (rsp_timeout),
    .apb_addr_out    (paddr),
    .apb_write_out   (pwrite),
    .apb_wdata_out   (pwdata),
    .apb_strb_out    (pstrb),
    .apb_psel_out    (psel),
    .apb_penable_out (penable),
    .apb_rdata_in    (prdata),
    .apb_ready_in    (pready),
    .apb_slverr_in   (pslverr)
  );

  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, psel, penable, rsp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_outs got %b exp 0000",
               {cmd_ready, psel, penable, rsp_valid});
    end
    n_checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL rst_data got %h exp 0", {paddr, pwdata, rsp_rdata});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release_ready got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    pready = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_t0_ready got %b exp 1", cmd_ready);
    end
    issue(32'hA030_0004, 1'b1, 32'h5A, 4'h1);
    n_checks++;
    if ({psel, penable, cmd_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_t1_setup got %b exp 100", {psel, penable, cmd_ready});
    end
    n_checks++;
    if ({paddr, pwrite, pwdata, pstrb} !== {32'hA030_0004, 1'b1, 32'h5A, 4'h1})
    begin
      n_fail++;
      $display("FAIL wr_t1_bus got %h %b %h %h exp a0300004 1 5a 1",
               paddr, pwrite, pwdata, pstrb);
    end
    @(negedge clk);
    n_checks++;
    if ({psel, penable, pstrb} !== {2'b11, 4'h1}) begin
      n_fail++;
      $display("FAIL wr_t2_access got %b %h exp 11 1", {psel, penable}, pstrb);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b10000) begin
      n_fail++;
      $display("FAIL wr_t3_rsp got %b exp 10000",
               {rsp_valid, rsp_err, rsp_timeout, psel, penable});
    end
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_rdata got %h exp 0", rsp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_t4_idle got %b exp 01", {rsp_valid, cmd_ready});
    end
    n_checks++;
    if ({paddr, pstrb} !== {32'hA030_0004, 4'h1}) begin
      n_fail++;
      $display("FAIL wr_hold got %h %h exp a0300004 1", paddr, pstrb);
    end
    pready = 1'b0;
  endtask

  task automatic test_read_wait();
    int pen = 0;
    int i;
    pready = 1'b0;
    prdata = 32'h10;
    issue(32'hA030_0000, 1'b0, 32'hFFFF_FFFF, 4'hF);
    n_checks++;
    if ({pwrite, pwdata, pstrb} !== 37'd0) begin
      n_fail++;
      $display("FAIL rd_zero_wd got %b %h %h exp 0 0 0", pwrite, pwdata, pstrb);
    end
    for (i = 0; i < 30; i++) begin
      if (rsp_valid) break;
      if (penable) begin
        pen++;
        if (pen == 4) pready = 1'b1;
      end
      @(negedge clk);
    end
    pready = 1'b0;
    n_checks++;
    if (pen !== 4) begin
      n_fail++;
      $display("FAIL rd_wait_penable got %0d exp 4", pen);
    end
    n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_wait_rsp got %b %h %b exp 1 10 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_single_rsp got %b exp 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_slverr();
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 32'hDEAD_BEEF;
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
      n_fail++;
      $display("FAIL slverr_flags got %b exp 110",
               {rsp_valid, rsp_err, rsp_timeout});
    end
    n_checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL slverr_rdata got %h exp deadbeef", rsp_rdata);
    end
    pready = 1'b0;
    pslverr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int pen = 0;
    int i;
    pready = 1'b0;
    prdata = 32'h1234;
    issue(32'h0000_0080, 1'b0, 32'h0, 4'h0);
    for (i = 0; i < 40; i++) begin
      if (rsp_valid) break;
      if (penable) pen++;
      @(negedge clk);
    end
    n_checks++;
    if (pen !== 16) begin
      n_fail++;
      $display("FAIL tmo_access_len got %0d exp 16", pen);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b11100) begin
      n_fail++;
      $display("FAIL tmo_flags got %b exp 11100",
               {rsp_valid, rsp_err, rsp_timeout, psel, penable});
    end
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_rdata got %h exp 0", rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    pready = 1'b1;
    rsp_ready = 1'b0;
    prdata = 32'h77;
    issue(32'h0000_0100, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0;
    prdata = 32'h99;
    cmd_addr = 32'h0000_0200;
    cmd_write = 1'b1;
    cmd_wdata = 32'hCAFE;
    cmd_strb = 4'h3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, cmd_ready, psel, rsp_rdata} !== {3'b100, 32'h77}) begin
        n_fail++;
        $display("FAIL bp_stall%0d got %b %h exp 100 77",
                 i, {rsp_valid, cmd_ready, psel}, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release got %b exp 010", {rsp_valid, cmd_ready, psel});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({psel, paddr, pstrb} !== {1'b1, 32'h0000_0200, 4'h3}) begin
      n_fail++;
      $display("FAIL bp_next_cmd got %b %h %h exp 1 200 3", psel, paddr, pstrb);
    end
    pready = 1'b1;
    repeat (3) @(negedge clk);
    pready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    pready = 1'b0;
    rsp_ready = 1'b1;
    issue(32'h0000_0300, 1'b1, 32'h1, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    pready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_drop got %b exp 0000",
               {psel, penable, rsp_valid, cmd_ready});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready got %b exp 1", cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || psel) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_rsp got %0d exp 0", seen);
    end
    pready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32: PADDR and command address width.
REQ-002 Parameter APB_DATA_WIDTH, default 32: PWDATA/PRDATA width; strobe width is APB_DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, legal range 2..255: maximum ACCESS-phase cycles before a transfer is aborted.
REQ-004 apb_clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 apb_rstn_in  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid_in  input  1  command request.
REQ-007 cmd_ready_out  output  1  command accepted when high together with cmd_valid_in.
REQ-008 cmd_addr_in  input  APB_ADDR_WIDTH  target address.
REQ-009 cmd_write_in  input  1  1 = write, 0 = read.
REQ-010 cmd_wdata_in  input  APB_DATA_WIDTH  write data.
REQ-011 cmd_strb_in  input  APB_DATA_WIDTH/8  byte-lane strobes for writes.
REQ-012 rsp_valid_out  output  1  response available.
REQ-013 rsp_ready_in  input  1  response consumed when high together with rsp_valid_out.
REQ-014 rsp_rdata_out  output  APB_DATA_WIDTH  read data; 0 for writes and aborted transfers.
REQ-015 rsp_err_out  output  1  PSLVERR seen or timeout.
REQ-016 rsp_timeout_out  output  1  transfer aborted by timeout.
REQ-017 apb_addr_out, apb_write_out, apb_wdata_out, apb_strb_out, apb_psel_out, apb_penable_out  outputs  APB widths  APB requester signals.
REQ-018 apb_rdata_in, apb_ready_in, apb_slverr_in  inputs  APB widths  APB completer signals.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; all APB and response outputs SHALL be registered.
REQ-020 cmd_ready_out SHALL be high only in IDLE; a handshake in IDLE SHALL capture addr/write/wdata/strb and move to SETUP on the next edge.
REQ-021 SETUP: psel=1, penable=0, captured fields on the APB bus; the next state SHALL always be ACCESS.
REQ-022 ACCESS: psel=1, penable=1, fields held stable; the FSM SHALL remain in ACCESS while apb_ready_in=0 and the timeout has not expired.
REQ-023 On apb_ready_in=1 in ACCESS: capture apb_rdata_in (reads; 0 for writes), rsp_err=apb_slverr_in, rsp_timeout=0, drop psel/penable, go to RESP.
REQ-024 A 5-bit wait counter SHALL clear on SETUP entry and increment each ACCESS cycle without ready; when it reaches TIMEOUT_CYCLES-1 with apb_ready_in=0 the transfer SHALL abort: rsp_rdata=0, rsp_err=1, rsp_timeout=1, psel/penable dropped, go to RESP.
REQ-025 apb_ready_in=1 on the cycle the counter expires SHALL count as normal completion, not a timeout.
REQ-026 RESP: rsp_valid_out=1 with data/flags stable until rsp_ready_in=1; then IDLE on the next edge.
REQ-027 Minimum transfer latency, zero-wait completer and rsp_ready held high: accept T0, SETUP T1, ACCESS T2, rsp_valid T3, cmd_ready again T4.
REQ-028 For reads apb_strb_out SHALL be 0 and apb_wdata_out SHALL be 0.
REQ-029 Outside SETUP/ACCESS psel and penable SHALL be 0; addr/write/wdata/strb SHALL hold their last values.
REQ-030 apb_ready_in, apb_rdata_in, and apb_slverr_in SHALL be ignored outside ACCESS.

Reset
REQ-031 While apb_rstn_in=0 at a clock edge: state=IDLE and all outputs 0, except cmd_ready_out, which SHALL become 1 on the first edge after release.
REQ-032 Reset during SETUP/ACCESS/RESP SHALL abandon the transfer and drop psel/penable on that edge, with no response generated.

Structure
REQ-033 Package apb_pkg SHALL hold the state encoding typedef, the default width and timeout constants, and the response flag bit positions.
REQ-034 The block SHALL be a single module with the wait counter inline; no sub-module is required.

Verification
REQ-035 Write 0xA0300004 data 0x5A strb 0x1, zero-wait completer -> SETUP then ACCESS with penable, pstrb=0x1; rsp_valid at T3 with rsp_err=0.
REQ-036 Read 0xA0300000 with 3 wait states returning 0x10 -> penable high 4 cycles, rsp_rdata=0x10, one response.
REQ-037 Read with pslverr=1 at completion -> rsp_err=1, rsp_timeout=0, rsp_rdata equals sampled prdata.
REQ-038 Completer never ready, TIMEOUT_CYCLES=16 -> ACCESS lasts 16 cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready low, new cmd_valid not accepted until after the response handshake.
REQ-040 apb_rstn_in low in the 2nd ACCESS cycle -> psel/penable 0 on that edge, no rsp_valid, cmd_ready=1 one cycle after release.
